// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave backed by a register-array memory. One outstanding
// transaction at a time; INCR/FIXED/WRAP bursts, byte strobes, and
// per-beat range checking (DECERR) plus whole-burst SLVERR for bad
// size or illegal WRAP length.
module axi_burst_mem_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);

    localparam int BYTES = DATA_W / 8;
    localparam int LOG_B = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic [1:0]          burst_q;
    logic                err_q;

    logic                idle;
    logic                w_fire;
    logic                w_err;
    logic                mem_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_len;
    logic [7:0]          w_beat;
    logic [1:0]          w_resp;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic [1:0]          r_resp;
    logic [DATA_W-1:0]   r_data;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        return (size != 3'(LOG_B)) || ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> LOG_B) < ADDR_W'(DEPTH);
    endfunction

    // DECERR > SLVERR > OKAY happens to match numeric order of the codes
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] mask;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << LOG_B) - ADDR_W'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return wrap_len_ok(len) ?
                            ((addr & ~mask) | ((addr + ADDR_W'(BYTES)) & mask)) :
                            (addr + ADDR_W'(BYTES));
            default: return addr + ADDR_W'(BYTES);
        endcase
    endfunction

    // Handshake readies: in IDLE a pending AW takes priority over AR
    always_comb begin
        awready = !rst && (state == IDLE) && awvalid;
        arready = !rst && (state == IDLE) && !awvalid;
        wready  = !rst && (((state == IDLE) && awvalid) || (state == WR_DATA));
    end

    // Beat decode: in IDLE the live AW/AR fields drive beat 0, later the latched ones
    always_comb begin
        idle   = (state == IDLE);
        w_addr = idle ? awaddr : addr_q;
        w_len  = idle ? awlen : len_q;
        w_beat = idle ? 8'd0 : beat_q;
        w_err  = idle ? burst_bad(awsize, awlen, awburst) : err_q;
        w_fire = wvalid && wready;
        w_resp = worst(w_err ? RESP_SLVERR : RESP_OKAY,
                       in_range(w_addr) ? RESP_OKAY : RESP_DECERR);
        if (wlast != (w_beat == w_len)) begin
            w_resp = worst(w_resp, RESP_SLVERR);
        end
        mem_we = w_fire && !w_err && in_range(w_addr);

        r_addr = idle ? araddr : addr_q;
        r_err  = idle ? burst_bad(arsize, arlen, arburst) : err_q;
        r_resp = !in_range(r_addr) ? RESP_DECERR : (r_err ? RESP_SLVERR : RESP_OKAY);
        r_data = (in_range(r_addr) && !r_err) ? mem[r_addr[LOG_B +: IDX_W]] : '0;
    end

    // Memory write port with byte enables; contents are never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[w_addr[LOG_B +: IDX_W]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM; addr_q always holds the address of the next beat to serve
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid) begin
                        bid     <= awid;
                        len_q   <= awlen;
                        burst_q <= awburst;
                        err_q   <= w_err;
                        if (w_fire) begin
                            addr_q <= next_addr(awaddr, awlen, awburst);
                            beat_q <= 8'd1;
                            bresp  <= w_resp;
                            if (awlen == 8'd0) begin
                                bvalid <= 1'b1;
                                state  <= WR_RESP;
                            end else begin
                                state  <= WR_DATA;
                            end
                        end else begin
                            addr_q <= awaddr;
                            beat_q <= 8'd0;
                            bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                            state  <= WR_DATA;
                        end
                    end else if (arvalid) begin
                        rid     <= arid;
                        len_q   <= arlen;
                        burst_q <= arburst;
                        err_q   <= r_err;
                        addr_q  <= next_addr(araddr, arlen, arburst);
                        beat_q  <= 8'd0;
                        rdata   <= r_data;
                        rresp   <= r_resp;
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        bresp  <= worst(bresp, w_resp);
                        addr_q <= next_addr(addr_q, len_q, burst_q);
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == len_q) begin
                            bvalid <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            rdata  <= r_data;
                            rresp  <= r_resp;
                            rlast  <= ((beat_q + 8'd1) == len_q);
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr(addr_q, len_q, burst_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: stimulus tasks push expected
// B/R responses computed from a byte-level memory model; a monitor pops
// and compares whenever a B or R handshake is presented.
module tb_axi_burst_mem_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst;
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    axi_burst_mem_slave #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [63:0] mask;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];

    // Reference memory: data plus per-byte "has been written" flags
    logic [63:0] mdl   [DEPTH];
    logic [7:0]  wmask [DEPTH];

    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    function automatic bit wrap_ok(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic bit bad_burst(input int size, input int len, input int burst);
        return (size != 3) || ((burst == 2) && !wrap_ok(len));
    endfunction

    // Address of beat i, from the burst rules with plain arithmetic
    function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                              input int burst, input int i);
        int unsigned a, win, base;
        a = (start / 8) * 8;
        if (burst == 0) return a;
        if ((burst == 2) && wrap_ok(len)) begin
            win  = int'(len + 1) * 8;
            base = (a / win) * win;
            return base + ((a - base + int'(i) * 8) % win);
        end
        return a + int'(i) * 8;
    endfunction

    // Monitor: compares each B/R handshake against the head of its queue
    initial begin
        rexp_t re;
        bexp_t be;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        chk("r_unexpected", rvalid, 0);
                    end else begin
                        re = rq.pop_front();
                        chk("rid", rid, re.id);
                        chk("rresp", rresp, re.resp);
                        chk("rlast", rlast, re.last);
                        chk("rdata", rdata & re.mask, re.data & re.mask);
                    end
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        chk("b_unexpected", bvalid, 0);
                    end else begin
                        be = bq.pop_front();
                        chk("bid", bid, be.id);
                        chk("bresp", bresp, be.resp);
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input bit with_aw,
                            input int bad_last, input bit gaps, input bit w_early);
        bexp_t        e;
        int           t;
        int unsigned  a, idx;
        bit           bad;
        bit           beat0;
        bad    = bad_burst(size, len, burst);
        e.id   = id;
        e.resp = bad ? 2'b10 : 2'b00;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, burst, i);
            idx = a / 8;
            if (idx >= DEPTH) e.resp = 2'b11;
            if ((i == bad_last) && (e.resp < 2'b10)) e.resp = 2'b10;
            if (!bad && (idx < DEPTH)) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[i][b]) begin
                        mdl[idx][8*b +: 8] = wd[i][8*b +: 8];
                        wmask[idx][b] = 1'b1;
                    end
                end
            end
        end
        bq.push_back(e);

        beat0 = with_aw || w_early;
        if (beat0) begin
            wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0];
            wlast  = (len == 0) ^ (bad_last == 0);
        end
        if (w_early) begin
            @(negedge clk);
            chk("w_stalled_before_aw", wready, 0);
            @(posedge clk); #1;
        end
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size);
        awburst = 2'(burst); awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 100) begin @(negedge clk); t++; end
        chk("awready", awready, 1);
        if (arvalid) chk("arready_blocked_by_aw", arready, 0);
        if (beat0) chk("w_in_aw_cycle", wready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;

        for (int i = (beat0 ? 1 : 0); i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast  = (i == len) ^ (i == bad_last);
            t = 0;
            @(negedge clk);
            while (!wready && t < 100) begin @(negedge clk); t++; end
            chk("wready", wready, 1);
            @(posedge clk); #1;
            wvalid = 1'b0;
        end

        t = 0;
        @(negedge clk);
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        chk("bvalid", bvalid, 1);
        @(posedge clk); #1;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int stall_lo,
                           input int stall_hi, input bit rand_stall, input int abort_at,
                           output int waited);
        rexp_t        e;
        logic [63:0]  ed [16];
        logic [63:0]  em [16];
        int           t;
        int unsigned  a, idx;
        bit           bad;
        bad = bad_burst(size, len, burst);
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, len, burst, i);
            idx    = a / 8;
            e.id   = id;
            e.last = (i == len);
            if (idx >= DEPTH) begin
                e.resp = 2'b11; e.data = '0; e.mask = '1;
            end else if (bad) begin
                e.resp = 2'b10; e.data = '0; e.mask = '1;
            end else begin
                e.resp = 2'b00; e.data = mdl[idx];
                for (int b = 0; b < 8; b++) e.mask[8*b +: 8] = {8{wmask[idx][b]}};
            end
            ed[i] = e.data; em[i] = e.mask;
            rq.push_back(e);
        end

        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size);
        arburst = 2'(burst); arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 100) begin @(negedge clk); t++; end
        waited = t;
        chk("arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_after_ar", rvalid, 1);
        @(posedge clk); #1;

        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rvalid_after_rst", rvalid, 0);
                chk("rdata_after_rst", rdata, 0);
                rq.delete();
                @(posedge clk); #1;
                break;
            end
            if (((i >= stall_lo) && (i <= stall_hi)) ||
                (rand_stall && ($urandom_range(0, 3) == 0))) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_rvalid", rvalid, 1);
                    chk("stall_rdata_held", rdata & em[i], ed[i] & em[i]);
                    @(posedge clk); #1;
                end
            end
            rready = 1'b1;
            t = 0;
            @(negedge clk);
            while (!rvalid && t < 100) begin @(negedge clk); t++; end
            chk("rvalid", rvalid, 1);
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int len, burst, size, bl;
        logic [31:0] addr;
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; wmask[i] = '0; end
        rst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rlast", rlast, 0);
        chk("idle_arready", arready, 1);
        chk("idle_wready", wready, 0);
        @(posedge clk); #1;

        // 16-beat burst with reserved burst type, beat 0 in the AW cycle
        for (int i = 0; i < 16; i++) begin wd[i] = 64'h1000 + 64'(i); ws[i] = 8'hFF; end
        do_write(4'd1, 32'h100, 15, 3, 3, 1'b1, -1, 1'b0, 1'b0);
        do_read(4'd1, 32'h100, 15, 3, 1, 5, 7, 1'b0, -1, w);

        // Partial strobe, with W presented before AW
        wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
        do_write(4'd5, 32'h108, 0, 3, 1, 1'b1, -1, 1'b0, 1'b1);
        do_read(4'd5, 32'h108, 0, 3, 1, -1, -1, 1'b0, -1, w);
        chk("partial_strobe_model", mdl[33], 64'h00000000_BBBBBBBB);

        // AW and AR together: write first, AR right after the B handshake
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        arid = 4'd3; araddr = 32'h200; arlen = 8'd1; arsize = 3'd3; arburst = 2'd1;
        arvalid = 1'b1;
        do_write(4'd2, 32'h200, 1, 3, 1, 1'b0, -1, 1'b0, 1'b0);
        do_read(4'd3, 32'h200, 1, 3, 1, -1, -1, 1'b0, -1, w);
        chk("ar_after_b_wait", w, 0);

        // Range boundary and bad size
        do_write(4'd4, 32'h1FF0, 3, 3, 1, 1'b0, -1, 1'b0, 1'b0);
        do_read(4'd4, 32'h1FF0, 3, 3, 1, -1, -1, 1'b0, -1, w);
        do_read(4'd6, 32'h100, 3, 2, 1, -1, -1, 1'b0, -1, w);

        // WRAP read, reset mid-burst, then accepted again
        do_read(4'd7, 32'h118, 3, 3, 2, -1, -1, 1'b0, -1, w);
        do_read(4'd7, 32'h118, 3, 3, 2, -1, -1, 1'b0, 2, w);
        do_read(4'd8, 32'h118, 3, 3, 2, 1, 1, 1'b0, -1, w);

        // wlast early / missing, illegal WRAP length, bad size, FIXED burst
        do_write(4'd9, 32'h300, 3, 3, 1, 1'b0, 1, 1'b0, 1'b0);
        do_write(4'd9, 32'h340, 3, 3, 1, 1'b1, 3, 1'b0, 1'b0);
        do_read(4'd9, 32'h300, 3, 3, 1, -1, -1, 1'b0, -1, w);
        do_write(4'd10, 32'h380, 2, 3, 2, 1'b0, -1, 1'b0, 1'b0);
        do_write(4'd11, 32'h3C0, 1, 2, 1, 1'b0, -1, 1'b0, 1'b0);
        do_read(4'd10, 32'h380, 2, 3, 1, -1, -1, 1'b0, -1, w);
        for (int i = 0; i < 4; i++) ws[i] = 8'h03 << (2 * i);
        do_write(4'd12, 32'h400, 3, 3, 0, 1'b0, -1, 1'b0, 1'b0);
        do_read(4'd12, 32'h400, 3, 3, 0, -1, -1, 1'b0, -1, w);

        // Randomized bursts, each read back with the same burst shape
        for (int n = 0; n < 40; n++) begin
            addr  = ($urandom_range(0, 1100) * 8) + $urandom_range(0, 7);
            burst = int'($urandom_range(0, 3));
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 2;
                endcase
            end else begin
                len = int'($urandom_range(0, 15));
            end
            size = ($urandom_range(0, 7) == 0) ? 2 : 3;
            bl   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            for (int i = 0; i < 16; i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'($urandom);
            end
            do_write(4'($urandom), addr, len, size, burst, 1'($urandom), bl, 1'b1, 1'b0);
            do_read(4'($urandom), addr, len, size, burst, -1, -1, 1'b1, -1, w);
        end

        repeat (5) @(posedge clk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
